// File: rtl/hex_display_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hex_display_scan_pkg
// Purpose  : Shared constants and leading-zero blanking helper for the
//            multiplexed hex display scanner.
// Revision : 1.0 - initial release
// ============================================================================
package hex_display_scan_pkg;

    localparam int   NIBBLE_W   = 4;
    localparam logic DIGIT_ON   = 1'b0;
    // Widest display the blanking helper supports; narrower words are zero-extended.
    localparam int   MAX_DIGITS = 32;

    // Bit i set when nibbles i..MAX_DIGITS-1 are all zero; digit 0 is never blanked.
    function automatic logic [MAX_DIGITS-1:0] lz_blank_mask(
        input logic [NIBBLE_W*MAX_DIGITS-1:0] word
    );
        logic [MAX_DIGITS-1:0] mask;
        logic                  zero_run;
        mask     = '0;
        zero_run = 1'b1;
        for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run && (word[i*NIBBLE_W +: NIBBLE_W] == '0);
            mask[i]  = zero_run;
        end
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hex_display_scan_tick_divider.sv
`default_nettype none
// ============================================================================
// Module   : tick_divider
// Purpose  : Free-running 0..DIV-1 counter with a pulse on the terminal count.
// Revision : 1.0 - initial release
// ============================================================================
module tick_divider #(
    parameter int DIV = 50000
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [$clog2(DIV)-1:0] cnt,
    output logic                   tick
);

    localparam int                 CNT_W  = $clog2(DIV);
    localparam logic [CNT_W-1:0]   c_last = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_cnt == c_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt  = r_cnt;
    assign tick = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/hex_display_scan.sv
`default_nettype none
// ============================================================================
// Module   : hex_display_scan
// Purpose  : Time-multiplexed 7-segment scanner with frame-aligned commit,
//            leading-zero blanking and an anti-ghosting guard interval.
// Revision : 1.0 - initial release
// ============================================================================
module hex_display_scan
    import hex_display_scan_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DIV    = 50000,
    parameter int GUARD  = 500
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic [NIBBLE_W*DIGITS-1:0] data_in,
    input  logic                       blank_lz,
    output logic [NIBBLE_W-1:0]        nibble,
    output logic [DIGITS-1:0]          digit_en,
    output logic                       frame_start,
    output logic                       pending
);

    localparam int                 CNT_W      = $clog2(DIV);
    localparam int                 IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int                 WORD_W     = NIBBLE_W * DIGITS;
    localparam logic [IDX_W-1:0]   c_idx_last = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0]   c_guard    = CNT_W'(GUARD);

    logic [CNT_W-1:0]      w_cnt;
    logic                  w_tick;
    logic                  w_boundary;
    logic [IDX_W-1:0]      r_idx;
    logic [WORD_W-1:0]     r_disp;
    logic [WORD_W-1:0]     r_shadow;
    logic                  r_pending;
    logic                  r_frame_start;
    logic [MAX_DIGITS-1:0] w_mask;
    logic                  w_blank;
    logic [DIGITS-1:0]     w_digit_en;

    tick_divider #(
        .DIV (DIV)
    ) u_tick_divider (
        .clk  (clk),
        .rst  (rst),
        .cnt  (w_cnt),
        .tick (w_tick)
    );

    assign w_boundary = w_tick && (r_idx == c_idx_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= '0;
        end else if (w_tick) begin
            r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
        end
    end

    // A load coinciding with the boundary bypasses the shadow so it is shown immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_disp        <= '0;
            r_shadow      <= '0;
            r_pending     <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_boundary;
            if (load) begin
                r_shadow <= data_in;
            end
            if (w_boundary) begin
                r_pending <= 1'b0;
                if (load) begin
                    r_disp <= data_in;
                end else if (r_pending) begin
                    r_disp <= r_shadow;
                end
            end else if (load) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign w_mask  = lz_blank_mask((NIBBLE_W*MAX_DIGITS)'(r_disp));
    assign w_blank = blank_lz && (r_idx != '0) && w_mask[r_idx];

    always_comb begin
        w_digit_en = '1;
        if ((w_cnt >= c_guard) && !w_blank) begin
            w_digit_en[r_idx] = DIGIT_ON;
        end
    end

    assign nibble      = r_disp[r_idx*NIBBLE_W +: NIBBLE_W];
    assign digit_en    = w_digit_en;
    assign frame_start = r_frame_start;
    assign pending     = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_hex_display_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_hex_display_scan
// Purpose  : Self-checking bench for hex_display_scan (DIGITS=4, DIV=8, GUARD=2)
//            against a cycle-count based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hex_display_scan;

    localparam int DIGITS = 4;
    localparam int DIV    = 8;
    localparam int GUARD  = 2;
    localparam int FRAME  = DIV * DIGITS;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] data_in;
    logic        blank_lz;
    logic [3:0]  nibble;
    logic [3:0]  digit_en;
    logic        frame_start;
    logic        pending;

    int errors = 0;
    int checks = 0;

    // Reference model: time since reset plus the word-level load/commit state.
    int          t;
    logic [15:0] m_disp;
    logic [15:0] m_shadow;
    logic        m_pend;

    hex_display_scan #(
        .DIGITS (DIGITS),
        .DIV    (DIV),
        .GUARD  (GUARD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .data_in     (data_in),
        .blank_lz    (blank_lz),
        .nibble      (nibble),
        .digit_en    (digit_en),
        .frame_start (frame_start),
        .pending     (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sig_digits(input logic [15:0] v);
        int s;
        s = 1;
        for (int i = 0; i < DIGITS; i++) begin
            if (((v >> (4 * i)) & 16'hF) != 0) s = i + 1;
        end
        return s;
    endfunction

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0d observed=%b expected=%b", tag, t, obs, exp);
        end
    endtask

    task automatic check_vec(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    // One clock: advance the model with the inputs present at the edge, then compare.
    task automatic cycle();
        int          cnt_e;
        int          idx_e;
        logic [3:0]  nib_e;
        logic [3:0]  en_e;
        logic        fs_e;
        logic        blanked;
        @(posedge clk);
        #1;
        if (rst) begin
            t        = 0;
            m_disp   = '0;
            m_shadow = '0;
            m_pend   = 1'b0;
        end else begin
            if (load) m_shadow = data_in;
            if ((t % FRAME) == FRAME - 1) begin
                if (load)        m_disp = data_in;
                else if (m_pend) m_disp = m_shadow;
                m_pend = 1'b0;
            end else if (load) begin
                m_pend = 1'b1;
            end
            t++;
        end
        cnt_e   = t % DIV;
        idx_e   = (t / DIV) % DIGITS;
        fs_e    = (t != 0) && ((t % FRAME) == 0);
        nib_e   = 4'((m_disp >> (4 * idx_e)) & 16'hF);
        blanked = blank_lz && (idx_e >= sig_digits(m_disp));
        en_e    = 4'hF;
        if (cnt_e >= GUARD && !blanked) en_e = ~(4'b0001 << idx_e);
        check_vec("nibble",      nibble,      nib_e);
        check_vec("digit_en",    digit_en,    en_e);
        check_bit("frame_start", frame_start, fs_e);
        check_bit("pending",     pending,     m_pend);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Advance until the model's next edge is at the given frame position.
    task automatic run_to(input int pos);
        for (int i = 0; i < FRAME && (t % FRAME) != pos; i++) cycle();
    endtask

    task automatic do_load(input logic [15:0] v);
        data_in = v;
        load    = 1'b1;
        cycle();
        load    = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        load     = 1'b0;
        data_in  = '0;
        blank_lz = 1'b0;
        t        = 0;
        m_disp   = '0;
        m_shadow = '0;
        m_pend   = 1'b0;

        run(2);
        check_vec("reset_digit_en", digit_en, 4'hF);
        rst = 1'b0;

        // Idle scan: zeros, walking enables, frame pulses
        run(64);

        // Mid-frame load during idx 1, committed at the next boundary
        run_to(10);
        do_load(16'h1A2F);
        check_bit("pending_after_load", pending, 1'b1);
        run_to(0);
        check_vec("commit_nibble0", nibble, 4'hF);
        check_bit("commit_pending", pending, 1'b0);
        run(40);

        // Latest load before the boundary wins
        run_to(4);
        do_load(16'h1111);
        run(6);
        do_load(16'h2222);
        run_to(0);
        check_vec("latest_wins", nibble, 4'h2);
        run(40);

        // Load exactly on the boundary cycle
        run_to(FRAME - 1);
        do_load(16'h00C3);
        check_vec("boundary_load_nibble", nibble, 4'h3);
        check_bit("boundary_load_pending", pending, 1'b0);
        check_bit("boundary_frame_start", frame_start, 1'b1);
        run(FRAME);

        // Leading-zero blanking
        blank_lz = 1'b1;
        do_load(16'h0005);
        run(2 * FRAME);
        do_load(16'h0000);
        run(2 * FRAME);
        do_load(16'h0105);
        run(2 * FRAME);
        blank_lz = 1'b0;

        // Reset mid-frame with a load pending (cnt=5, idx=2)
        run_to(3);
        do_load(16'hBEEF);
        run_to(2 * DIV + 5);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_vec("rst_digit_en", digit_en, 4'hF);
        check_vec("rst_nibble", nibble, 4'h0);
        check_bit("rst_pending", pending, 1'b0);
        run(2 * FRAME);

        // Random loads, data and blanking
        for (int i = 0; i < 3000; i++) begin
            load    = ($urandom_range(0, 11) == 0);
            data_in = 16'($urandom);
            if ($urandom_range(0, 3) == 0) data_in = data_in & 16'h00FF;
            if ($urandom_range(0, 63) == 0) blank_lz = ~blank_lz;
            cycle();
        end
        load = 1'b0;
        run(FRAME);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hex_display_scan.md
Name: hex_display_scan

Overview:
Time-multiplexed scanner for a multi-digit 7-segment display.
- Captures a hex word on a load strobe and holds it in a shadow register.
- Commits the shadow to the displayed word only at a frame boundary, so the display never tears.
- Each scan slot drives one 4-bit nibble to the downstream hex segment decoder, plus active-low digit enables.
- Supports leading-zero blanking and an anti-ghosting guard interval at the start of each slot.

Parameters:
DIGITS, 4, number of display digits (>=1).
DIV, 50000, clock cycles per digit slot (>=2).
GUARD, 500, cycles at slot start with all digits off (0 <= GUARD < DIV).

Ports:
clk  in  1  system clock.
rst  in  1  synchronous active-high reset.
load  in  1  one-cycle strobe: capture data_in.
data_in  in  4*DIGITS  hex word; nibble i goes to digit i, digit 0 least significant.
blank_lz  in  1  enable leading-zero blanking (level, sampled every cycle).
nibble  out  4  value of the current digit, to the segment decoder input.
digit_en  out  DIGITS  active-low digit enables; at most one bit is 0.
frame_start  out  1  one-cycle pulse when a new frame begins (commit point).
pending  out  1  a loaded value is waiting for commit.

Behaviour:
- The block is single-clock. Reset is synchronous and active-high on rst; everything updates on the rising edge of clk.
- Reset state:
  - slot counter cnt=0, digit index idx=0.
  - disp=0, shadow=0, pending=0, frame_start=0.
  - nibble=0; digit_en all 1s while GUARD>0.
- Prescaler: cnt counts 0..DIV-1 and wraps. The cycle with cnt==DIV-1 is the slot tick.
- On a slot tick, idx advances modulo DIGITS.
- Frame boundary: a slot tick where idx==DIGITS-1, i.e. idx wraps to 0.
  - Registered frame_start is 1 in the first cycle of the new frame (cnt==0, idx==0). Otherwise it is 0.
- Load path:
  - load=1 writes data_in to shadow and sets pending=1.
  - A later load before commit overwrites shadow; the latest value wins.
- Commit at frame boundary:
  - If pending, disp <= shadow and pending <= 0.
  - If load is asserted in the same cycle as the boundary, data_in is committed directly to disp. Shadow is also updated and pending ends at 0.
  - Without pending or load, disp is unchanged.
- All outputs are functions of registered state only. There is no combinational path from load, data_in or blank_lz to the outputs, except blank_lz into digit_en.
  - A committed value appears on nibble in the first cycle of the new frame.
- nibble = disp[4*idx+3 : 4*idx].
- Digit idx is blanked when all of the following hold:
  - blank_lz=1
  - idx != 0
  - nibbles idx..DIGITS-1 of disp are all zero
  - Consequence: value 0 shows a single "0" on digit 0.
- digit_en[idx]=0 only when cnt >= GUARD and the digit is not blanked. All other bits are always 1.
- With DIGITS=1: idx stays 0 and every slot tick is a frame boundary.
- Reset mid-frame: the state returns to the reset state on the next edge and any pending load is discarded.
- Widths:
  - cnt uses $clog2(DIV) bits.
  - idx uses max(1, $clog2(DIGITS)) bits.
  - All comparisons are unsigned.

Decomposition:
- Shared display package holds:
  - NIBBLE_W=4
  - the active-low enable convention constant (DIGIT_ON=1'b0)
  - a function computing the leading-zero blank mask for a 4*N-bit word.
- One natural sub-module: tick_divider (parameter DIV).
  - Outputs cnt and a tick pulse.
  - Reusable by other timing blocks.
- The segment decoder is instantiated by the parent, not inside this block.

Test Plan:
All scenarios use DIGITS=4, DIV=8, GUARD=2.
1. Reset, then run 64 cycles with no load.
   - nibble=0 throughout.
   - idx steps 0,1,2,3 every 8 cycles.
   - digit_en goes 1111 at cnt 0-1, then 1110, 1101, 1011, 0111 at cnt 2-7 in successive slots.
   - frame_start pulses every 32 cycles.
2. Load 0x1A2F mid-frame at idx=1.
   - pending=1 until the boundary, and disp does not change mid-frame.
   - Next frame shows F, 2, A, 1 on idx 0..3.
   - pending=0 after the commit.
3. Load 0x1111, then 0x2222 before the boundary.
   - Only 0x2222 is ever displayed.
4. Assert load with 0x00C3 in exactly the boundary cycle.
   - The next frame shows 3, C, 0, 0.
   - pending=0.
5. Load 0x0005 with blank_lz=1.
   - Only digit 0 is ever enabled, showing 5.
   - Value 0x0000 enables digit 0 only.
   - Value 0x0105 enables digits 0, 1 and 2 (digit 1 shows 0); digit 3 stays off.
6. Assert rst at cnt=5, idx=2, with pending=1.
   - The next cycle has cnt=0, idx=0, pending=0, disp=0 and digit_en=1111.
